// File: rtl/lab4_imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the program loader.
// master = loader side, slave = stream source / memory side.
interface lab4_imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lab4_imem_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words and writes
// them to instruction memory, holding the CPU in reset until a load completes.
module lab4_imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     word_count,
  lab4_imem_loader_if.master  bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   target_q, target_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   start_target;
  logic [ADDR_W:0]   word_inc;

  assign start_target = (word_count > DEPTH_C) ? DEPTH_C : word_count;
  assign word_inc     = word_cnt_q + (ADDR_W+1)'(1);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    target_d     = target_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    buf_d        = buf_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d   = start_target;
          err_d      = (word_count > DEPTH_C);
          byte_cnt_d = '0;
          word_cnt_d = '0;
          if (start_target == '0) begin
            state_d      = DONE;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            cpu_hold_d   = 1'b0;
            byte_ready_d = 1'b0;
          end else begin
            state_d      = LOAD;
            done_d       = 1'b0;
            busy_d       = 1'b1;
            cpu_hold_d   = 1'b1;
            byte_ready_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (bus.byte_valid && byte_ready_q) begin
          // Shifting left leaves byte 0 in bits [31:24] once four have arrived.
          buf_d = {buf_q[15:0], bus.byte_data};
          if (byte_cnt_q == 2'd3) begin
            mem_wdata_d  = {buf_q, bus.byte_data};
            mem_addr_d   = word_cnt_q[ADDR_W-1:0];
            mem_we_d     = 1'b1;
            byte_ready_d = 1'b0;
            byte_cnt_d   = '0;
            state_d      = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      WRITE: begin
        mem_we_d   = 1'b0;
        word_cnt_d = word_inc;
        if (word_inc == target_q) begin
          state_d      = DONE;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          cpu_hold_d   = 1'b0;
          byte_ready_d = 1'b0;
        end else begin
          state_d      = LOAD;
          byte_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the word buffer is a handful of flops, not a memory array, so it is
  // cleared on reset along with the counters to drop any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      buf_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      buf_q        <= buf_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
